shifter_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 4-bit doubler/shifter unit among N_REQ requesters.
- The unit takes 4-bit data and a 3-bit control and has registered output.
- Accepts one request at a time, drives the unit's operands, waits the unit's latency, captures the result, and returns it tagged with the requester id.
- Sits between the requesting blocks and the single shared unit instance.

---
 rtl/shifter_rr_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_shifter_rr_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : shifter_rr_scheduler
// Description : Round-robin scheduler sharing one 4-bit doubler/shifter unit
//               among N_REQ requesters. One request is accepted at a time;
//               its operands are driven onto the unit, the result is
//               captured after UNIT_LATENCY edges and returned tagged with
//               the requester id.
// Optional    : `define SHIFTER_SCHED_OP_COUNT_EN builds per-requester 8-bit
//               completed-operation counters on op_count; otherwise op_count
//               is tied to zero.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req_valid/data/control - packed per-requester request fields
//               req_ready           - one-hot combinational accept strobe
//               unit_data_in/control- registered operands to shared unit
//               unit_data_out       - result from shared unit
//               resp_valid/id/data  - one-cycle tagged response
//               busy                - scheduler not idle
//               op_count            - per-requester completion counters
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_rr_scheduler #(
  parameter int N_REQ        = 4,
  parameter int UNIT_LATENCY = 1,
  localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_data,
  input  logic [3*N_REQ-1:0]   req_control,
  output logic [N_REQ-1:0]     req_ready,
  output logic [3:0]           unit_data_in,
  output logic [2:0]           unit_control,
  input  logic [3:0]           unit_data_out,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [3:0]           resp_data,
  output logic                 busy,
  output logic [8*N_REQ-1:0]   op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] C_LAT = CNT_W'(UNIT_LATENCY);
  localparam logic [ID_W-1:0]  C_LAST_RST = ID_W'(N_REQ - 1);

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]      unit_data_q, unit_data_d;
  logic [2:0]      unit_ctrl_q, unit_ctrl_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [3:0]      resp_data_q, resp_data_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand_idx;
  logic [3:0]      sel_data;
  logic [2:0]      sel_ctrl;
  logic            capture;

  // Search offsets from N_REQ down to 1 so the smallest offset after
  // last_grant (i.e. the next requester in round-robin order) wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
      if (req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Constant-index mux keeps the selected fields free of variable slicing.
  always_comb begin
    sel_data  = '0;
    sel_ctrl  = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_data     = req_data[4*i +: 4];
        sel_ctrl     = req_control[3*i +: 3];
        req_ready[i] = grant_vld && (state_q == S_IDLE);
      end
    end
  end

  assign capture = (state_q == S_BUSY) && (cnt_q == C_LAT);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    unit_data_d  = unit_data_q;
    unit_ctrl_d  = unit_ctrl_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          unit_data_d  = sel_data;
          unit_ctrl_d  = sel_ctrl;
          grant_id_d   = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = '0;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (capture) begin
          resp_data_d  = unit_data_out;
          resp_id_d    = grant_id_q;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        unit_data_d = '0;
        unit_ctrl_d = '0;
        state_d     = S_IDLE;
      end
      default: begin
        unit_data_d = '0;
        unit_ctrl_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= C_LAST_RST;
      grant_id_q   <= '0;
      cnt_q        <= '0;
      unit_data_q  <= '0;
      unit_ctrl_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      unit_data_q  <= unit_data_d;
      unit_ctrl_q  <= unit_ctrl_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign unit_data_in = unit_data_q;
  assign unit_control = unit_ctrl_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_data    = resp_data_q;
  assign busy         = (state_q != S_IDLE);

`ifdef SHIFTER_SCHED_OP_COUNT_EN
  // Each slice counts on the edge entering RESP for its own requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_op_cnt
    logic [7:0] cnt_slice_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_slice_q <= '0;
      end else if (capture && (grant_id_q == ID_W'(i))) begin
        cnt_slice_q <= cnt_slice_q + 8'd1;
      end
    end
    assign op_count[8*i +: 8] = cnt_slice_q;
  end
`else
  assign op_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shifter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_rr_scheduler
// Description : Self-checking bench for shifter_rr_scheduler (N_REQ=4,
//               UNIT_LATENCY=1) with a unit model returning data+1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_rr_scheduler;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [11:0] req_control = '0;
  logic [3:0]  req_ready;
  logic [3:0]  unit_data_in;
  logic [2:0]  unit_control;
  logic [3:0]  unit_data_out;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [3:0]  resp_data;
  logic        busy;
  logic [31:0] op_count;

  shifter_rr_scheduler #(.N_REQ(N), .UNIT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_control(req_control),
    .req_ready(req_ready),
    .unit_data_in(unit_data_in), .unit_control(unit_control),
    .unit_data_out(unit_data_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Shared unit model: one registered stage, result = data + 1.
  logic [3:0] unit_q = '0;
  always @(posedge clk) unit_q <= unit_data_in + 4'd1;
  assign unit_data_out = unit_q;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  int         exp_id[$];
  logic [3:0] exp_data[$];
  int         exp_cyc[$];
  int         grant_log[$];
  int         resp_log[$];

  // Scoreboard: push on accept, pop and compare on response.
  always @(negedge clk) begin
    int gid;
    int eid;
    int ec;
    logic [3:0] ed;
    if (req_ready != 4'b0000) begin
      gid = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
      n_checks++;
      if ($countones(req_ready) != 1 || req_valid[gid] !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL accept_strobe: req_ready=%b req_valid=%b busy=%b, required one-hot within req_valid while idle",
                 req_ready, req_valid, busy);
      end
      exp_id.push_back(gid);
      exp_data.push_back(req_data[4*gid +: 4] + 4'd1);
      exp_cyc.push_back(cyc + 2 + LAT);
      grant_log.push_back(gid);
    end
    if (resp_valid === 1'b1) begin
      n_checks++;
      if (exp_id.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 id=%0d data=%h at cycle %0d, required no response", resp_id, resp_data, cyc);
      end else begin
        eid = exp_id.pop_front();
        ed  = exp_data.pop_front();
        ec  = exp_cyc.pop_front();
        if (resp_id !== 2'(eid) || resp_data !== ed || cyc != ec) begin
          n_fail++;
          $display("FAIL resp_match: got id=%0d data=%h cycle=%0d, required id=%0d data=%h cycle=%0d",
                   resp_id, resp_data, cyc, eid, ed, ec);
        end
      end
      resp_log.push_back(cyc);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    resp_log.delete();
  endtask

  task automatic wait_resps(input int n, input int budget, output bit ok);
    int cnt = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) cnt++;
      if (cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_accept(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, req_ready, resp_valid, unit_data_in, unit_control, resp_id, resp_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: busy=%b ready=%b rv=%b udi=%h uc=%b rid=%0d rd=%h, required all zero",
                 busy, req_ready, resp_valid, unit_data_in, unit_control, resp_id, resp_data);
      end
    end
    n_checks++;
    if (op_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_op_count: op_count=%h, required 0", op_count);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_data[11:8]   = 4'h3;
    req_control[8:6] = 3'b010;
    req_valid        = 4'b0100;
    wait_accept(20, ok);
    n_checks++;
    if (!ok || req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_accept: ok=%0d req_ready=%b, required 0100", ok, req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (unit_data_in !== 4'h3 || unit_control !== 3'b010 || busy !== 1'b1 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_operands_A+%0d: udi=%h uc=%b busy=%b rv=%b, required 3 010 1 0",
                 c, unit_data_in, unit_control, busy, resp_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 4'h4) begin
      n_fail++;
      $display("FAIL single_resp: rv=%b id=%0d data=%h, required 1 2 4", resp_valid, resp_id, resp_data);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 4'h4 || resp_id !== 2'd2 ||
        unit_data_in !== 4'h0 || unit_control !== 3'b000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: rv=%b id=%0d rd=%h udi=%h uc=%b busy=%b, required 0 2 4 0 0 0",
               resp_valid, resp_id, resp_data, unit_data_in, unit_control, busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_data    = 16'hDA52;
    req_control = 12'b101_011_110_001;
    req_valid   = 4'b1111;
    wait_resps(5, 60, ok);
    @(posedge clk); #1 req_valid = '0;
    n_checks++;
    if (!ok || grant_log.size() != 5) begin
      n_fail++;
      $display("FAIL rr_count: ok=%0d grants=%0d, required 5", ok, grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (grant_log[i] != order[i]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: grant=%0d, required %0d", i, grant_log[i], order[i]);
        end
      end
      for (int i = 1; i < resp_log.size(); i++) begin
        n_checks++;
        if (resp_log[i] - resp_log[i-1] != 3 + LAT) begin
          n_fail++;
          $display("FAIL rr_spacing[%0d]: gap=%0d, required %0d", i, resp_log[i] - resp_log[i-1], 3 + LAT);
        end
      end
    end
  endtask

  task automatic test_skip_wrap();
    bit ok;
    int order[3] = '{1, 3, 1};
    do_reset();
    req_data  = 16'h8E61;
    req_valid = 4'b1010;
    wait_resps(3, 40, ok);
    @(posedge clk); #1 req_valid = '0;
    n_checks++;
    if (!ok || grant_log.size() != 3) begin
      n_fail++;
      $display("FAIL skip_count: ok=%0d grants=%0d, required 3", ok, grant_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (grant_log[i] != order[i]) begin
          n_fail++;
          $display("FAIL skip_order[%0d]: grant=%0d, required %0d", i, grant_log[i], order[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    req_data  = 16'h4C97;
    req_valid = 4'b0010;
    wait_accept(20, ok);
    n_checks++;
    if (!ok || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_accept: ok=%0d req_ready=%b, required 0010", ok, req_ready);
    end
    // Now in the first BUSY cycle: reset here abandons the operation.
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    exp_id.delete();
    exp_data.delete();
    exp_cyc.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || unit_data_in !== 4'h0 || unit_control !== 3'b000) begin
        n_fail++;
        $display("FAIL mid_abandon: rv=%b busy=%b udi=%h uc=%b, required all 0",
                 resp_valid, busy, unit_data_in, unit_control);
      end
    end
    @(posedge clk); #1 req_valid = 4'b0101;
    wait_accept(20, ok);
    n_checks++;
    if (!ok || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_regrant: ok=%0d req_ready=%b, required 0001", ok, req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_resps(1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_resp_timeout: got none, required 1 response");
    end
  endtask

  task automatic test_op_count();
    bit ok;
    logic [31:0] exp_cnt;
`ifdef SHIFTER_SCHED_OP_COUNT_EN
    exp_cnt = 32'h0000_0001;
`else
    exp_cnt = 32'h0000_0000;
`endif
    do_reset();
    req_data[3:0] = 4'h7;
    req_valid     = 4'b0001;
    wait_resps(257, 257 * (3 + LAT) + 20, ok);
    @(posedge clk); #1 req_valid = '0;
    n_checks++;
    if (!ok || grant_log.size() != 257) begin
      n_fail++;
      $display("FAIL opcnt_ops: ok=%0d grants=%0d, required 257", ok, grant_log.size());
    end
    @(negedge clk);
    n_checks++;
    if (op_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL op_count: op_count=%h, required %h", op_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_reset_mid();
    test_op_count();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_id.size() != 0) begin
      n_fail++;
      $display("FAIL pending_resp: %0d outstanding, required 0", exp_id.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
